sng16_parallel: RTL

Parallel stochastic number generator, 16 lanes. Converts a binary probability level into a burst of 16-bit stochastic bit vectors, one vector per accepted beat. The 16-bit approximate parallel counter consumes these vectors, so this block is its source end. Lanes compare rotated views of one shared LFSR against the level. The expected number of ones per beat is 16·level/256.

---
 rtl/sng_pkg.sv | 21 ++
 rtl/sng_lfsr16.sv | 28 ++
 rtl/sng16_parallel.sv | 91 +++++++++
 3 files changed

// File: rtl/sng_pkg.sv
// Shared definitions for the 16-lane stochastic number generator: FSM states,
// lane count, LFSR taps/seed and the probability scale.
package sng_pkg;

    localparam int          LANES             = 16;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    localparam logic [8:0]  LEVEL_MAX         = 9'd256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sng_state_e;

    // Levels above full scale are clamped so every lane reads as "always one".
    function automatic logic [8:0] sat_level(input logic [8:0] lvl);
        return (lvl > LEVEL_MAX) ? LEVEL_MAX : lvl;
    endfunction

endpackage

// File: rtl/sng_lfsr16.sv
// 16-bit left-shifting Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with a step enable.
module sng_lfsr16
    import sng_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_advance,
    output logic [15:0] o_state
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    assign w_feedback = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (i_advance) begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/sng16_parallel.sv
// Burst-oriented parallel SNG: each accepted beat emits 16 lanes, lane i set when
// the low byte of the LFSR rotated left by i is below the latched level.
module sng16_parallel
    import sng_pkg::*;
#(
    parameter int          LEN_W     = 8,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [8:0]       level,
    input  logic [LEN_W-1:0] length,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_bits,
    output logic             out_last,
    output logic             done
);

    sng_state_e       r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [8:0]       r_level;

    logic [15:0]      w_lfsr;
    logic             w_accept;
    logic             w_cnt_one;
    logic [LANES-1:0] w_lane_bits;
    logic [7:0]       w_lane_byte [LANES];

    assign ready     = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign w_accept  = out_valid & out_ready;
    assign w_cnt_one = (r_cnt == LEN_W'(1));
    assign out_last  = out_valid & w_cnt_one;
    assign out_bits  = out_valid ? w_lane_bits : 16'h0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_level <= sat_level(level);
                        r_cnt   <= length;
                        r_state <= (length != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (w_cnt_one) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sng_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_accept),
        .o_state   (w_lfsr)
    );

    // Only the low byte of each rotated view is needed, so wire it up bit by bit.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            for (genvar bi = 0; bi < 8; bi++) begin : g_bit
                assign w_lane_byte[gi][bi] = w_lfsr[(bi + LANES - gi) % LANES];
            end
            assign w_lane_bits[gi] = ({1'b0, w_lane_byte[gi]} < r_level);
        end
    endgenerate

endmodule
